// File: rtl/ysyx_24120013_operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage.
//   - of_state_e : stage state (IDLE empty / READ RF data arriving / HOLD stalled)
//   - ZERO_REG   : index of the hard-wired zero register
//   - OF_*_WIDTH : default widths used by the top and the bypass sub-module
package ysyx_24120013_operand_fetch_pkg;

  localparam int unsigned OF_ADDR_WIDTH    = 32'd5;
  localparam int unsigned OF_DATA_WIDTH    = 32'd32;
  localparam int unsigned OF_PAYLOAD_WIDTH = 32'd64;
  localparam int unsigned ZERO_REG         = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_HOLD = 2'b10
  } of_state_e;

endpackage

// File: rtl/ysyx_24120013_operand_fetch_bypass.sv
// Per-operand bypass: remembers which register the op reads, whether a
// writeback hit it at the accept edge, keeps a hold copy while execute stalls,
// masks x0 and selects the value presented to execute.
// Ports:
//   clk, rst          clock, async active-high reset
//   i_accept          op accepted at this edge (latch i_rs, forward snoop)
//   i_rs              incoming source register index
//   i_capture         READ cycle stalling: load hold reg at this edge
//   i_holding         stage is in HOLD: present hold reg
//   i_rf_rdata        registered RF read data
//   i_wb_wen/waddr/wdata  writeback snoop
//   o_data            operand presented to execute
module ysyx_24120013_operand_bypass
  import ysyx_24120013_operand_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = OF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = OF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_accept,
  input  logic [ADDR_WIDTH-1:0] i_rs,
  input  logic                  i_capture,
  input  logic                  i_holding,
  input  logic [DATA_WIDTH-1:0] i_rf_rdata,
  input  logic                  i_wb_wen,
  input  logic [ADDR_WIDTH-1:0] i_wb_waddr,
  input  logic [DATA_WIDTH-1:0] i_wb_wdata,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);

  logic [ADDR_WIDTH-1:0] r_rs;
  logic                  r_fwd;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [DATA_WIDTH-1:0] r_hold;

  logic                  w_new_hit;
  logic                  w_cur_hit;
  logic [DATA_WIDTH-1:0] w_read_val;

  // Writeback snoop compares and operand select (x0 masked, forward beats stale RF data)
  always_comb begin
    w_new_hit  = i_wb_wen & (i_wb_waddr == i_rs) & (i_rs != ZR);
    w_cur_hit  = i_wb_wen & (i_wb_waddr == r_rs) & (r_rs != ZR);
    w_read_val = '0;
    if (r_rs == ZR) begin
      w_read_val = '0;
    end else if (r_fwd) begin
      w_read_val = r_fwd_data;
    end else begin
      w_read_val = i_rf_rdata;
    end
    if (i_holding) begin
      o_data = r_hold;
    end else begin
      o_data = w_read_val;
    end
  end

  // Operand tracking state: index/forward latched on accept, hold reg follows writebacks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs       <= '0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
      r_hold     <= '0;
    end else begin
      if (i_accept) begin
        r_rs       <= i_rs;
        r_fwd      <= w_new_hit;
        r_fwd_data <= i_wb_wdata;
      end
      // A write landing on the stall edge is newer than the value being presented.
      if (i_capture) begin
        r_hold <= w_cur_hit ? i_wb_wdata : w_read_val;
      end else if (i_holding && w_cur_hit) begin
        r_hold <= i_wb_wdata;
      end
    end
  end

endmodule

// File: rtl/ysyx_24120013_operand_fetch.sv
// Operand-fetch stage between decode and execute.
// Accepts decoded ops (valid/ready), drives the registered RF read ports,
// merges RF data with writeback forwarding and holds operands under stall.
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready              decode handshake
//   in_rs1/in_rs2/in_payload       decoded op
//   rf_raddr1/2, rf_rdata1/2       RF read ports (data one cycle after address)
//   wb_wen/wb_waddr/wb_wdata       writeback (same nets as RF write port)
//   out_valid/out_ready            execute handshake
//   out_rs1_data/out_rs2_data      operands
//   out_payload                    registered sideband
module ysyx_24120013_operand_fetch
  import ysyx_24120013_operand_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = OF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = OF_DATA_WIDTH,
  parameter int unsigned PAYLOAD_WIDTH = OF_PAYLOAD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_rs1,
  input  logic [ADDR_WIDTH-1:0]    in_rs2,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic [ADDR_WIDTH-1:0]    rf_raddr1,
  output logic [ADDR_WIDTH-1:0]    rf_raddr2,
  input  logic [DATA_WIDTH-1:0]    rf_rdata1,
  input  logic [DATA_WIDTH-1:0]    rf_rdata2,
  input  logic                     wb_wen,
  input  logic [ADDR_WIDTH-1:0]    wb_waddr,
  input  logic [DATA_WIDTH-1:0]    wb_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_rs1_data,
  output logic [DATA_WIDTH-1:0]    out_rs2_data,
  output logic [PAYLOAD_WIDTH-1:0] out_payload
);

  of_state_e                r_state;
  of_state_e                w_state_nxt;
  logic [PAYLOAD_WIDTH-1:0] r_payload;
  logic                     w_accept;
  logic                     w_capture;
  logic                     w_holding;

  // RF addresses follow decode directly so data arrives the cycle after accept
  assign rf_raddr1   = in_rs1;
  assign rf_raddr2   = in_rs2;
  assign w_accept    = in_valid & in_ready;
  assign out_payload = r_payload;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ, ST_HOLD: begin
        if (out_ready) begin
          w_state_nxt = w_accept ? ST_READ : ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs and bypass controls
  always_comb begin
    out_valid = 1'b0;
    w_capture = 1'b0;
    w_holding = 1'b0;
    case (r_state)
      ST_IDLE: out_valid = 1'b0;
      ST_READ: begin
        out_valid = 1'b1;
        w_capture = ~out_ready;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        w_holding = 1'b1;
      end
      default: out_valid = 1'b0;
    endcase
    in_ready = (r_state == ST_IDLE) | (out_valid & out_ready);
  end

  // Sideband register, loaded only on accept so it stays stable under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_payload <= '0;
    end else if (w_accept) begin
      r_payload <= in_payload;
    end else begin
      r_payload <= r_payload;
    end
  end

  ysyx_24120013_operand_bypass #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bypass_rs1 (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_accept),
    .i_rs       (in_rs1),
    .i_capture  (w_capture),
    .i_holding  (w_holding),
    .i_rf_rdata (rf_rdata1),
    .i_wb_wen   (wb_wen),
    .i_wb_waddr (wb_waddr),
    .i_wb_wdata (wb_wdata),
    .o_data     (out_rs1_data)
  );

  ysyx_24120013_operand_bypass #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bypass_rs2 (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_accept),
    .i_rs       (in_rs2),
    .i_capture  (w_capture),
    .i_holding  (w_holding),
    .i_rf_rdata (rf_rdata2),
    .i_wb_wen   (wb_wen),
    .i_wb_waddr (wb_waddr),
    .i_wb_wdata (wb_wdata),
    .o_data     (out_rs2_data)
  );

endmodule

// File: tb/tb_ysyx_24120013_operand_fetch.sv
// Bench for ysyx_24120013_operand_fetch: a behavioural register file plus a
// queue of accepted ops serve as the reference. While an op is presented, its
// operands must equal the architectural register contents of that cycle.
module tb_ysyx_24120013_operand_fetch;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs1, in_rs2;
  logic [PW-1:0] in_payload;
  logic [AW-1:0] rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic          wb_wen;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_rs1_data, out_rs2_data;
  logic [PW-1:0] out_payload;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24120013_operand_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_payload   (in_payload),
    .rf_raddr1    (rf_raddr1),
    .rf_raddr2    (rf_raddr2),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .wb_wen       (wb_wen),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_payload  (out_payload)
  );

  // Register file with registered read ports; x0 is never written.
  logic [DW-1:0] rf [0:31];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_wen && wb_waddr != 5'd0) begin
      rf[wb_waddr] <= wb_wdata;
    end
    rf_rdata1 <= rf[rf_raddr1];
    rf_rdata2 <= rf[rf_raddr2];
  end

  // Reference: queue of accepted ops, head is the op presented to execute.
  typedef struct packed {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [PW-1:0] payload;
  } op_t;
  op_t q[$];

  always @(posedge clk or posedge rst) begin : ref_model
    bit  hs, acc;
    op_t o;
    if (rst) begin
      q.delete();
    end else begin
      hs  = (q.size() != 0) && out_ready;
      acc = in_valid && ((q.size() == 0) || out_ready);
      if (hs) void'(q.pop_front());
      if (acc) begin
        o.rs1 = in_rs1; o.rs2 = in_rs2; o.payload = in_payload;
        q.push_back(o);
      end
    end
  end

  function automatic logic [DW-1:0] arch(input logic [AW-1:0] r);
    return (r == 5'd0) ? 32'd0 : rf[r];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [PW-1:0] pl, input logic ordy,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_payload = pl; out_ready = ordy;
    wb_wen = we; wb_waddr = wa; wb_wdata = wd;
  endtask

  task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b0, 5'd0, 5'd0, 64'd0, 1'b1, 1'b1, a, d);
    tick();
    wb_wen = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 5'd0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_payload !== 64'd0) begin errors++; $display("FAIL reset_payload got %h want 0", out_payload); end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    wb_write(5'd3, 32'h33);
    drive(1'b1, 5'd3, 5'd3, 64'hDEAD_0001, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (out_rs1_data !== 32'h33) begin errors++; $display("FAIL hold_before_reset got %h want 33", out_rs1_data); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_hold_valid got %b want 0", out_valid); end
    tick(); tick();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_reset_in_ready got %b want 1", in_ready); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_op got out_valid %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_single();
    wb_write(5'd5, 32'h11);
    drive(1'b1, 5'd5, 5'd0, 64'h0000_0002_CAFE_0002, 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_rs1_data !== 32'h11) begin errors++; $display("FAIL single_rs1 got %h want 11", out_rs1_data); end
    checks++; if (out_rs2_data !== 32'h0) begin errors++; $display("FAIL single_rs2 got %h want 0", out_rs2_data); end
    checks++; if (out_payload !== 64'h0000_0002_CAFE_0002) begin errors++; $display("FAIL single_payload got %h want 00000002cafe0002", out_payload); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_beat got %b want 0", out_valid); end
  endtask

  task automatic test_fwd_at_accept();
    wb_write(5'd7, 32'h5555);
    drive(1'b1, 5'd7, 5'd5, 64'h3, 1'b1, 1'b1, 5'd7, 32'hABCD);
    tick();
    in_valid = 1'b0; wb_wen = 1'b0;
    @(negedge clk);
    checks++; if (out_rs1_data !== 32'hABCD) begin errors++; $display("FAIL fwd_accept_rs1 got %h want abcd", out_rs1_data); end
    checks++; if (out_rs2_data !== 32'h11) begin errors++; $display("FAIL fwd_accept_rs2 got %h want 11", out_rs2_data); end
    tick();
  endtask

  task automatic test_hold();
    drive(1'b1, 5'd7, 5'd7, 64'h4444, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    // A waiting op is offered throughout the stall and must not be taken early.
    drive(1'b1, 5'd5, 5'd7, 64'h5555, 1'b0, 1'b1, 5'd7, 32'h1);
    @(negedge clk);
    checks++; if (out_rs1_data !== 32'hABCD) begin errors++; $display("FAIL hold_c0_rs1 got %h want abcd", out_rs1_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_c0_in_ready got %b want 0", in_ready); end
    tick();
    wb_wdata = 32'h2;
    @(negedge clk);
    checks++; if (out_rs2_data !== 32'h1) begin errors++; $display("FAIL hold_c1_rs2 got %h want 1", out_rs2_data); end
    tick();
    wb_wen = 1'b0;
    @(negedge clk);
    checks++; if (out_rs1_data !== 32'h2) begin errors++; $display("FAIL hold_c2_rs1 got %h want 2", out_rs1_data); end
    checks++; if (out_rs2_data !== 32'h2) begin errors++; $display("FAIL hold_c2_rs2 got %h want 2", out_rs2_data); end
    checks++; if (out_payload !== 64'h4444) begin errors++; $display("FAIL hold_payload got %h want 4444", out_payload); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_c2_in_ready got %b want 0", in_ready); end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_payload !== 64'h5555) begin errors++; $display("FAIL waiting_op_payload got %h want 5555", out_payload); end
    checks++; if (out_rs1_data !== 32'h11 || out_rs2_data !== 32'h2) begin errors++; $display("FAIL waiting_op_operands got %h/%h want 11/2", out_rs1_data, out_rs2_data); end
    tick();
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 5'd0, 64'h6, 1'b1, 1'b1, 5'd0, 32'hFFFF);
    tick();
    in_valid = 1'b0; wb_wen = 1'b0;
    @(negedge clk);
    checks++; if (out_rs1_data !== 32'd0 || out_rs2_data !== 32'd0) begin errors++; $display("FAIL x0_operands got %h/%h want 0/0", out_rs1_data, out_rs2_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] r1 [4];
    logic [AW-1:0] r2 [4];
    logic [PW-1:0] pl [4];
    for (int i = 0; i < 4; i++) begin
      r1[i] = 5'(i + 3); r2[i] = 5'(7 - i); pl[i] = 64'hB2B0_0000_0000_0000 | 64'(i);
    end
    drive(1'b1, r1[0], r2[0], pl[0], 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) drive(1'b1, r1[k], r2[k], pl[k], 1'b1, 1'b0, 5'd0, 32'd0);
      else in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_payload !== pl[k-1] ||
          out_rs1_data !== arch(r1[k-1]) || out_rs2_data !== arch(r2[k-1])) begin
        errors++;
        $display("FAIL b2b_beat%0d got v=%b pl=%h op=%h/%h want v=1 pl=%h op=%h/%h", k-1,
                 out_valid, out_payload, out_rs1_data, out_rs2_data, pl[k-1], arch(r1[k-1]), arch(r2[k-1]));
      end
      tick();
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_random();
    logic          exp_v, exp_r;
    logic [DW-1:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            {$urandom, $urandom}, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom);
      @(negedge clk);
      exp_v = (q.size() != 0);
      exp_r = !exp_v || out_ready;
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rand_valid cyc%0d got %b want %b", n, out_valid, exp_v); end
      checks++; if (in_ready !== exp_r) begin errors++; $display("FAIL rand_in_ready cyc%0d got %b want %b", n, in_ready, exp_r); end
      if (exp_v) begin
        e1 = arch(q[0].rs1); e2 = arch(q[0].rs2);
        checks++;
        if (out_payload !== q[0].payload || out_rs1_data !== e1 || out_rs2_data !== e2) begin
          errors++;
          $display("FAIL rand_op cyc%0d got pl=%h op=%h/%h want pl=%h op=%h/%h", n,
                   out_payload, out_rs1_data, out_rs2_data, q[0].payload, e1, e2);
        end
      end
      tick();
    end
    drive(1'b0, 5'd0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    test_reset();
    test_reset_mid_hold();
    test_single();
    test_fwd_at_accept();
    test_hold();
    test_x0();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
